// File: rtl/rf_read_stage.sv
// rf_read_stage: operand select (forwarded / writeback bypass / regfile) into a single registered multi-lane stage.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : per-lane input valids; whole-bundle accept handshake
//   in_op*_ready, in_operand* : operands already captured upstream
//   in_prs*, rf_rs*_data : physical source indices and same-cycle regfile data
//   in_ctrl, in_rob_tag  : pass-through control and ROB tag
//   wb_valid/preg/data   : same-cycle writeback bypass ports (lowest index wins)
//   flush                : kill the stage contents and the current input
//   out_*                : registered bundle, lane data zero when lane invalid
module rf_read_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 64,
  parameter int PRW   = 6,
  parameter int WB    = 2,
  parameter int CW    = 26,
  parameter int TW    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LANES-1:0]      in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_op1_ready,
  input  logic [LANES-1:0]      in_op2_ready,
  input  logic [LANES*PRW-1:0]  in_prs1,
  input  logic [LANES*PRW-1:0]  in_prs2,
  input  logic [LANES*XLEN-1:0] rf_rs1_data,
  input  logic [LANES*XLEN-1:0] rf_rs2_data,
  input  logic [LANES*XLEN-1:0] in_operand1,
  input  logic [LANES*XLEN-1:0] in_operand2,
  input  logic [LANES*CW-1:0]   in_ctrl,
  input  logic [LANES*TW-1:0]   in_rob_tag,
  input  logic [WB-1:0]         wb_valid,
  input  logic [WB*PRW-1:0]     wb_preg,
  input  logic [WB*XLEN-1:0]    wb_data,
  input  logic                  flush,
  output logic [LANES-1:0]      out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_operand1,
  output logic [LANES*XLEN-1:0] out_operand2,
  output logic [LANES*CW-1:0]   out_ctrl,
  output logic [LANES*TW-1:0]   out_rob_tag
);
  logic [LANES*XLEN-1:0] d_op1, d_op2;
  logic [LANES*CW-1:0]   d_ctrl;
  logic [LANES*TW-1:0]   d_tag;
  assign in_ready = (~|out_valid | out_ready) & ~flush;
  // Bypass ports are scanned high to low so the lowest matching port ends up winning;
  // a forwarded operand then overrides everything, and invalid lanes are zeroed.
  always_comb begin
    d_op1  = rf_rs1_data;
    d_op2  = rf_rs2_data;
    d_ctrl = '0;
    d_tag  = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = WB - 1; j >= 0; j--) begin
        if (wb_valid[j] && in_prs1[i*PRW +: PRW] != '0 && wb_preg[j*PRW +: PRW] == in_prs1[i*PRW +: PRW])
          d_op1[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
        if (wb_valid[j] && in_prs2[i*PRW +: PRW] != '0 && wb_preg[j*PRW +: PRW] == in_prs2[i*PRW +: PRW])
          d_op2[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
      end
      d_op1[i*XLEN +: XLEN] = !in_valid[i] ? '0 : in_op1_ready[i] ? in_operand1[i*XLEN +: XLEN] : d_op1[i*XLEN +: XLEN];
      d_op2[i*XLEN +: XLEN] = !in_valid[i] ? '0 : in_op2_ready[i] ? in_operand2[i*XLEN +: XLEN] : d_op2[i*XLEN +: XLEN];
      d_ctrl[i*CW +: CW]    = in_valid[i] ? in_ctrl[i*CW +: CW] : '0;
      d_tag[i*TW +: TW]     = in_valid[i] ? in_rob_tag[i*TW +: TW] : '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset || flush) begin
      out_valid    <= '0;
      out_operand1 <= '0;
      out_operand2 <= '0;
      out_ctrl     <= '0;
      out_rob_tag  <= '0;
    end else if (in_ready) begin
      out_valid    <= in_valid;
      out_operand1 <= d_op1;
      out_operand2 <= d_op2;
      out_ctrl     <= d_ctrl;
      out_rob_tag  <= d_tag;
    end
  end
endmodule

// File: tb/tb_rf_read_stage.sv
// tb_rf_read_stage: randomized and directed checks of rf_read_stage against a behavioural model.
module tb_rf_read_stage;
  localparam int L = 2, X = 64, P = 6, W = 2, C = 26, T = 4;
  localparam int L4 = 4, X4 = 32;
  logic clock = 0, reset = 1;
  logic [L-1:0] in_valid, in_op1_ready, in_op2_ready, out_valid;
  logic in_ready, flush, out_ready;
  logic [L*P-1:0] in_prs1, in_prs2;
  logic [L*X-1:0] rf_rs1_data, rf_rs2_data, in_operand1, in_operand2, out_operand1, out_operand2;
  logic [L*C-1:0] in_ctrl, out_ctrl;
  logic [L*T-1:0] in_rob_tag, out_rob_tag;
  logic [W-1:0] wb_valid;
  logic [W*P-1:0] wb_preg;
  logic [W*X-1:0] wb_data;
  logic [L4-1:0] w_in_valid, w_op1_ready, w_op2_ready, w_out_valid;
  logic w_in_ready;
  logic [L4*P-1:0] w_prs1, w_prs2;
  logic [L4*X4-1:0] w_rf1, w_rf2, w_opd1, w_opd2, w_out1, w_out2;
  logic [L4*C-1:0] w_ctrl, w_out_ctrl;
  logic [L4*T-1:0] w_tag, w_out_tag;
  logic [W-1:0] w_wb_valid;
  logic [W*P-1:0] w_wb_preg;
  logic [W*X4-1:0] w_wb_data;
  logic [L-1:0] m_valid;
  logic [X-1:0] m_op1 [L];
  logic [X-1:0] m_op2 [L];
  logic [C-1:0] m_ctrl [L];
  logic [T-1:0] m_tag [L];
  int vectors = 0, errors = 0;
  always #5 clock = ~clock;
  rf_read_stage #(.LANES(L), .XLEN(X), .PRW(P), .WB(W), .CW(C), .TW(T)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1_ready(in_op1_ready), .in_op2_ready(in_op2_ready), .in_prs1(in_prs1), .in_prs2(in_prs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .in_ctrl(in_ctrl), .in_rob_tag(in_rob_tag), .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_operand1(out_operand1),
    .out_operand2(out_operand2), .out_ctrl(out_ctrl), .out_rob_tag(out_rob_tag));
  rf_read_stage #(.LANES(L4), .XLEN(X4), .PRW(P), .WB(W), .CW(C), .TW(T)) dut4 (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_op1_ready(w_op1_ready), .in_op2_ready(w_op2_ready), .in_prs1(w_prs1), .in_prs2(w_prs2),
    .rf_rs1_data(w_rf1), .rf_rs2_data(w_rf2), .in_operand1(w_opd1), .in_operand2(w_opd2),
    .in_ctrl(w_ctrl), .in_rob_tag(w_tag), .wb_valid(w_wb_valid), .wb_preg(w_wb_preg), .wb_data(w_wb_data),
    .flush(1'b0), .out_valid(w_out_valid), .out_ready(1'b1), .out_operand1(w_out1),
    .out_operand2(w_out2), .out_ctrl(w_out_ctrl), .out_rob_tag(w_out_tag));

  function automatic logic [X-1:0] pick(logic rdy, logic [X-1:0] opv, logic [P-1:0] prs, logic [X-1:0] rf);
    if (rdy) return opv;
    if (prs == 0) return rf;
    for (int j = 0; j < W; j++)
      if (wb_valid[j] && wb_preg[j*P +: P] == prs) return wb_data[j*X +: X];
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = '0;
    for (int i = 0; i < L; i++) begin
      m_op1[i] = '0; m_op2[i] = '0; m_ctrl[i] = '0; m_tag[i] = '0;
    end
  endtask

  task automatic clear_in();
    in_valid = '0; in_op1_ready = '0; in_op2_ready = '0; in_prs1 = '0; in_prs2 = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; in_operand1 = '0; in_operand2 = '0;
    in_ctrl = '0; in_rob_tag = '0; wb_valid = '0; wb_preg = '0; wb_data = '0; flush = 0;
  endtask

  task automatic set_lane(int i, logic v, logic r1, logic r2, logic [P-1:0] p1, logic [P-1:0] p2,
                          logic [X-1:0] rf1, logic [X-1:0] rf2, logic [X-1:0] o1, logic [X-1:0] o2,
                          logic [C-1:0] c, logic [T-1:0] t);
    in_valid[i] = v; in_op1_ready[i] = r1; in_op2_ready[i] = r2;
    in_prs1[i*P +: P] = p1; in_prs2[i*P +: P] = p2;
    rf_rs1_data[i*X +: X] = rf1; rf_rs2_data[i*X +: X] = rf2;
    in_operand1[i*X +: X] = o1; in_operand2[i*X +: X] = o2;
    in_ctrl[i*C +: C] = c; in_rob_tag[i*T +: T] = t;
  endtask

  task automatic tick();
    logic rdy;
    rdy = !(|m_valid) || out_ready;
    if (flush) model_clear();
    else if (rdy) begin
      m_valid = in_valid;
      for (int i = 0; i < L; i++) begin
        m_op1[i]  = in_valid[i] ? pick(in_op1_ready[i], in_operand1[i*X +: X], in_prs1[i*P +: P], rf_rs1_data[i*X +: X]) : '0;
        m_op2[i]  = in_valid[i] ? pick(in_op2_ready[i], in_operand2[i*X +: X], in_prs2[i*P +: P], rf_rs2_data[i*X +: X]) : '0;
        m_ctrl[i] = in_valid[i] ? in_ctrl[i*C +: C] : '0;
        m_tag[i]  = in_valid[i] ? in_rob_tag[i*T +: T] : '0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (out_valid !== '0 || out_operand1 !== '0 || out_operand2 !== '0 || out_ctrl !== '0 || out_rob_tag !== '0) begin
      errors++; $display("FAIL reset_outputs got valid=%b op1=%h ctrl=%h exp all zero", out_valid, out_operand1, out_ctrl);
    end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    reset = 0;
    model_clear();
    @(posedge clock); #1;
  endtask

  task automatic test_operand_select();
    clear_in(); out_ready = 1;
    set_lane(0, 1, 1, 0, 6'd3, 6'd4, 64'h77, 64'h22, 64'h11, 64'h55, 26'h1234, 4'h7);
    tick();
    vectors++;
    if (out_valid !== 2'b01) begin errors++; $display("FAIL sel_valid got %b exp 01", out_valid); end
    vectors++;
    if (out_operand1[0 +: X] !== 64'h11 || out_operand2[0 +: X] !== 64'h22) begin
      errors++; $display("FAIL sel_operands got %h/%h exp 11/22", out_operand1[0 +: X], out_operand2[0 +: X]);
    end
    vectors++;
    if (out_operand1[X +: X] !== '0 || out_ctrl[C +: C] !== '0 || out_ctrl[0 +: C] !== 26'h1234) begin
      errors++; $display("FAIL sel_lane_zero got op1_l1=%h ctrl=%h exp lane1 zero ctrl0=1234", out_operand1[X +: X], out_ctrl);
    end
  endtask

  task automatic test_bypass();
    clear_in(); out_ready = 1;
    set_lane(0, 1, 0, 0, 6'd5, 6'd9, 64'h99, 64'h66, 64'h0, 64'h0, 26'h1, 4'h1);
    wb_valid = 2'b11; wb_preg = {6'd5, 6'd5}; wb_data = {64'hBB, 64'hAA};
    tick();
    vectors++;
    if (out_operand1[0 +: X] !== 64'hAA) begin errors++; $display("FAIL bypass_lowest got %h exp aa", out_operand1[0 +: X]); end
    vectors++;
    if (out_operand2[0 +: X] !== 64'h66) begin errors++; $display("FAIL bypass_nomatch got %h exp 66", out_operand2[0 +: X]); end
    set_lane(0, 1, 0, 0, 6'd0, 6'd0, 64'h99, 64'h98, 64'h0, 64'h0, 26'h1, 4'h1);
    wb_preg = {6'd0, 6'd0};
    tick();
    vectors++;
    if (out_operand1[0 +: X] !== 64'h99 || out_operand2[0 +: X] !== 64'h98) begin
      errors++; $display("FAIL bypass_preg0 got %h/%h exp 99/98", out_operand1[0 +: X], out_operand2[0 +: X]);
    end
  endtask

  task automatic test_hold();
    clear_in(); out_ready = 1;
    set_lane(0, 1, 1, 1, 6'd1, 6'd2, 64'h0, 64'h0, 64'hA0, 64'hA1, 26'hA, 4'hA);
    set_lane(1, 1, 1, 1, 6'd1, 6'd2, 64'h0, 64'h0, 64'hB0, 64'hB1, 26'hB, 4'hB);
    tick();
    out_ready = 0;
    set_lane(0, 1, 1, 1, 6'd1, 6'd2, 64'h0, 64'h0, 64'hC0, 64'hC1, 26'hC, 4'hC);
    set_lane(1, 1, 0, 0, 6'd1, 6'd2, 64'hD0, 64'hD1, 64'h0, 64'h0, 26'hD, 4'hD);
    wb_valid = 2'b01; wb_preg = {6'd0, 6'd1}; wb_data = {64'h0, 64'hEE};
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc%0d got %b exp 0", k, in_ready); end
      tick();
      vectors++;
      if (out_valid !== 2'b11 || out_operand1 !== {64'hB0, 64'hA0} || out_operand2 !== {64'hB1, 64'hA1} || out_rob_tag !== 8'hBA) begin
        errors++; $display("FAIL hold_stable cyc%0d got %b %h %h exp 11 b0a0 b1a1", k, out_valid, out_operand1, out_operand2);
      end
    end
    out_ready = 1; #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
    tick();
    vectors++;
    if (out_operand1 !== {64'hEE, 64'hC0} || out_operand2 !== {64'hD1, 64'hC1} || out_ctrl !== {26'hD, 26'hC}) begin
      errors++; $display("FAIL hold_new_bundle got %h %h exp ee/c0 d1/c1", out_operand1, out_operand2);
    end
  endtask

  task automatic test_flush();
    clear_in(); out_ready = 1;
    set_lane(0, 1, 1, 1, 6'd1, 6'd1, 64'h0, 64'h0, 64'h31, 64'h32, 26'h3, 4'h3);
    set_lane(1, 1, 1, 1, 6'd1, 6'd1, 64'h0, 64'h0, 64'h41, 64'h42, 26'h4, 4'h4);
    tick();
    out_ready = 0; flush = 1; #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 0;
    vectors++;
    if (out_valid !== '0 || out_operand1 !== '0 || out_operand2 !== '0 || out_ctrl !== '0 || out_rob_tag !== '0) begin
      errors++; $display("FAIL flush_clear got valid=%b op1=%h ctrl=%h exp all zero", out_valid, out_operand1, out_ctrl);
    end
  endtask

  task automatic test_reset_mid();
    clear_in(); out_ready = 1;
    set_lane(0, 1, 1, 1, 6'd1, 6'd1, 64'h0, 64'h0, 64'h51, 64'h52, 26'h5, 4'h5);
    set_lane(1, 1, 1, 1, 6'd1, 6'd1, 64'h0, 64'h0, 64'h61, 64'h62, 26'h6, 4'h6);
    tick();
    out_ready = 0;
    #2 reset = 1;
    #1;
    vectors++;
    if (out_valid !== '0 || out_operand1 !== '0 || out_operand2 !== '0 || out_rob_tag !== '0) begin
      errors++; $display("FAIL midreset_outputs got valid=%b op1=%h exp zero", out_valid, out_operand1);
    end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b exp 1", in_ready); end
    reset = 0;
    model_clear();
    clear_in();
    set_lane(0, 1, 1, 1, 6'd1, 6'd1, 64'h0, 64'h0, 64'h71, 64'h72, 26'h7, 4'h7);
    tick();
    vectors++;
    if (out_valid !== 2'b01 || out_operand1[0 +: X] !== 64'h71) begin
      errors++; $display("FAIL midreset_empty got %b %h exp 01 71", out_valid, out_operand1[0 +: X]);
    end
  endtask

  task automatic test_wide();
    w_in_valid = 4'b1011; w_op1_ready = 4'b0101; w_op2_ready = 4'b0000;
    w_prs1 = {6'd0, 6'd7, 6'd7, 6'd2}; w_prs2 = {6'd1, 6'd1, 6'd1, 6'd1};
    w_rf1 = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; w_rf2 = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    w_opd1 = {32'h0, 32'hA2, 32'h0, 32'hA0}; w_opd2 = '0;
    w_ctrl = {26'h33, 26'h22, 26'h11, 26'h5}; w_tag = {4'h3, 4'h2, 4'h1, 4'h9};
    w_wb_valid = 2'b11; w_wb_preg = {6'd7, 6'd0}; w_wb_data = {32'hC1, 32'hE0};
    @(posedge clock); #1;
    vectors++;
    if (w_out_valid !== 4'b1011) begin errors++; $display("FAIL wide_valid got %b exp 1011", w_out_valid); end
    vectors++;
    if (w_out1 !== {32'hD3, 32'h0, 32'hC1, 32'hA0}) begin errors++; $display("FAIL wide_op1 got %h exp d3_0_c1_a0", w_out1); end
    vectors++;
    if (w_out2 !== {32'hF3, 32'h0, 32'hF1, 32'hF0}) begin errors++; $display("FAIL wide_op2 got %h exp f3_0_f1_f0", w_out2); end
    vectors++;
    if (w_out_ctrl[2*C +: C] !== '0 || w_out_tag !== 16'h3019 || w_out_ctrl[0 +: C] !== 26'h5) begin
      errors++; $display("FAIL wide_lane2 got ctrl=%h tag=%h exp lane2 zero tag 3019", w_out_ctrl, w_out_tag);
    end
    w_in_valid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear_in();
      for (int i = 0; i < L; i++)
        set_lane(i, 1'($urandom), 1'($urandom), 1'($urandom), P'($urandom_range(0, 3)), P'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 C'($urandom), T'($urandom));
      wb_valid = W'($urandom);
      wb_preg = {P'($urandom_range(0, 3)), P'($urandom_range(0, 3))};
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 15) == 0;
      #1;
      vectors++;
      if (in_ready !== ((!(|m_valid) || out_ready) && !flush)) begin
        errors++; $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, in_ready, (!(|m_valid) || out_ready) && !flush);
      end
      tick();
      vectors++;
      if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, m_valid); end
      for (int i = 0; i < L; i++) begin
        vectors++;
        if (out_operand1[i*X +: X] !== m_op1[i] || out_operand2[i*X +: X] !== m_op2[i] ||
            out_ctrl[i*C +: C] !== m_ctrl[i] || out_rob_tag[i*T +: T] !== m_tag[i]) begin
          errors++;
          $display("FAIL rnd_lane%0d n=%0d got %h %h %h %h exp %h %h %h %h", i, n, out_operand1[i*X +: X], out_operand2[i*X +: X],
                   out_ctrl[i*C +: C], out_rob_tag[i*T +: T], m_op1[i], m_op2[i], m_ctrl[i], m_tag[i]);
        end
      end
    end
  endtask

  initial begin
    clear_in(); out_ready = 1;
    w_in_valid = '0; w_op1_ready = '0; w_op2_ready = '0; w_prs1 = '0; w_prs2 = '0; w_rf1 = '0; w_rf2 = '0;
    w_opd1 = '0; w_opd2 = '0; w_ctrl = '0; w_tag = '0; w_wb_valid = '0; w_wb_preg = '0; w_wb_data = '0;
    model_clear();
    test_reset();
    test_operand_select();
    test_bypass();
    test_hold();
    test_flush();
    test_reset_mid();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rf_read_stage.md
RF_READ_STAGE -- requirements
Module: rf_read_stage

Parameters
REQ-001 LANES, default 2: number of issue lanes, all advanced together.
REQ-002 XLEN, default 64: operand width.
REQ-003 PRW, default 6: physical-register index width.
REQ-004 WB, default 2: number of writeback bypass ports.
REQ-005 CW, default 26: packed control width (sub_op, fu_type, des_index, pred_taken, lsq_tag), passed through unmodified.
REQ-006 TW, default 4: ROB tag width.

Interface
REQ-007 clock  in  1  single clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 in_valid  in  LANES  lane i carries an instruction.
REQ-010 in_ready  out  1  stage accepts the input bundle this cycle.
REQ-011 in_op1_ready, in_op2_ready  in  LANES each  operand already captured in in_operand1/2.
REQ-012 in_prs1, in_prs2  in  LANES*PRW each  physical source indices.
REQ-013 rf_rs1_data, rf_rs2_data  in  LANES*XLEN each  register-file read data for in_prs1/2, same cycle.
REQ-014 in_operand1, in_operand2  in  LANES*XLEN each  pre-captured operand values.
REQ-015 in_ctrl  in  LANES*CW; in_rob_tag  in  LANES*TW.
REQ-016 wb_valid  in  WB; wb_preg  in  WB*PRW; wb_data  in  WB*XLEN  same-cycle writeback bypass.
REQ-017 flush  in  1  kill everything in the stage.
REQ-018 out_valid  out  LANES; out_ready  in  1  downstream accepts the whole bundle.
REQ-019 out_operand1, out_operand2  out  LANES*XLEN; out_ctrl  out  LANES*CW; out_rob_tag  out  LANES*TW.

Function
REQ-020 One registered stage per lane; latency from accept to out_valid is exactly 1 cycle.
REQ-021 in_ready = !(|out_valid) | out_ready, combinational; in_ready forced 0 while flush=1.
REQ-022 Accept = in_ready & !flush; on accept every lane register loads, out_valid[i] <= in_valid[i], including lanes with in_valid=0.
REQ-023 Hold: when |out_valid & !out_ready & !flush, all stage registers keep their value; the bundle never partially retires.
REQ-024 Drain: out_ready=1 with no accept is impossible (in_ready=1 then), so an idle input (all in_valid=0) clears out_valid on the next edge.
REQ-025 Operand select per source, per lane, priority: opN_ready -> in_operandN; else lowest-index wb port j with wb_valid[j] and wb_preg[j]==prsN and prsN!=0 -> wb_data[j]; else rf_rsN_data.
REQ-026 Physical register 0 never bypasses; its value comes from rf data.
REQ-027 Selected operand, in_ctrl, in_rob_tag captured only for valid lanes; invalid lanes capture zero.
REQ-028 All data outputs of a lane are zero whenever out_valid[i]=0.
REQ-029 flush=1: out_valid <= 0 on the next edge; input that cycle is discarded; flush overrides out_ready and any held bundle.
REQ-030 No bypass update to a held bundle; operands are frozen at capture.

Reset
REQ-031 reset=1 asynchronously clears out_valid and all data registers to 0; in_ready reads 1 during reset.
REQ-032 Reset mid-hold discards the held bundle; first edge after release behaves as empty stage.

Verification
REQ-033 Lane0 valid, op1_ready=1, in_operand1=0x11, op2 not ready, rf_rs2=0x22 -> next cycle out_valid=01, operand1=0x11, operand2=0x22.
REQ-034 prs1=5, wb_valid=11, wb_preg={5,5}, wb_data={0xBB,0xAA} (port0=0xAA), rf=0x99 -> operand1=0xAA; prs1=0 with wb_preg=0 -> rf value.
REQ-035 Bundle captured, out_ready=0 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 -> in_ready=1, new bundle appears next cycle.
REQ-036 Held bundle plus flush=1 with in_valid=11 -> next cycle out_valid=00, all outputs 0, no input captured.
REQ-037 reset asserted between edges while out_valid=11 -> outputs 0 immediately, in_ready=1.
REQ-038 LANES=4, XLEN=32 build: per-lane independence of selects, lane2 invalid -> lane2 outputs 0.
